// File: rtl/mult_booth_r4_pkg.sv
// rtl/mult_booth_r4_pkg.sv - shared types and helpers for the radix-4 Booth multiplier
// Contents:
//   state_t        : control FSM states (IDLE, RUN, DONE)
//   booth_digit_t  : decoded radix-4 Booth digit selecting 0, +/-A or +/-2A
//   ext_w()        : extended operand width for a given operand width
//   iter_cnt()     : number of radix-4 digits retired for a given operand width
//   booth_decode() : multiplier triplet -> Booth digit
package mult_booth_r4_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_POS1 = 3'd1,
        BD_POS2 = 3'd2,
        BD_NEG1 = 3'd3,
        BD_NEG2 = 3'd4
    } booth_digit_t;

    // Two guard bits let unsigned operands be treated as positive signed
    // values and keep the digit count an integer.
    function automatic int ext_w(input int w);
        return w + 2;
    endfunction

    function automatic int iter_cnt(input int w);
        return w / 2 + 1;
    endfunction

    // Triplet is {b[2i+1], b[2i], b[2i-1]} with an implicit 0 below the LSB.
    function automatic booth_digit_t booth_decode(input logic [2:0] trip);
        booth_digit_t d;
        case (trip)
            3'b001, 3'b010: d = BD_POS1;
            3'b011:         d = BD_POS2;
            3'b100:         d = BD_NEG2;
            3'b101, 3'b110: d = BD_NEG1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sign_zero_extend.sv
// rtl/sign_zero_extend.sv - widen an operand by sign or zero extension
// Ports:
//   is_signed : 1 = replicate din MSB into the new bits, 0 = fill with zero
//   din       : IN_W-bit input operand
//   dout      : OUT_W-bit extended operand (OUT_W must exceed IN_W)
module sign_zero_extend #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 34
) (
    input  logic             is_signed,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    assign dout = {{(OUT_W-IN_W){is_signed & din[IN_W-1]}}, din};

endmodule

// File: rtl/mult_booth_r4.sv
// rtl/mult_booth_r4.sv - sequential radix-4 Booth multiplier, one digit per clock
// Ports:
//   clock        : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   start        : begin a multiply (accepted in IDLE or DONE only)
//   is_signed    : operand mode, captured with start
//   multiplicand : operand A, captured with start
//   multiplier   : operand B, captured with start
//   busy         : operation in progress
//   done         : one-cycle pulse, product/ovf valid
//   product      : 2*WIDTH-bit result, held until the next done
//   ovf          : product does not fit in WIDTH bits for the captured mode
// WIDTH must be even and at least 4.
module mult_booth_r4
    import mult_booth_r4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               ovf
);

    localparam int EXT_W = ext_w(WIDTH);
    localparam int ITER  = iter_cnt(WIDTH);
    localparam int ACC_W = EXT_W + 2;
    localparam int CNT_W = $clog2(ITER);

    state_t state_q, state_d;

    logic [EXT_W-1:0]   a_ext, b_ext;
    logic [EXT_W-1:0]   a_q;
    logic [ACC_W-1:0]   hi_q;
    logic [EXT_W-1:0]   lo_q;
    logic               prev_q;
    logic               signed_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] product_q;
    logic               ovf_q;

    booth_digit_t       digit;
    logic [ACC_W-1:0]   a_acc, a2_acc, addend, sum;
    logic [ACC_W-1:0]   next_hi;
    logic [EXT_W-1:0]   next_lo;
    logic [2*WIDTH-1:0] final_prod;
    logic               final_ovf;
    logic               accept, last_step;

    sign_zero_extend #(.IN_W(WIDTH), .OUT_W(EXT_W)) u_ext_a (
        .is_signed (is_signed),
        .din       (multiplicand),
        .dout      (a_ext)
    );

    sign_zero_extend #(.IN_W(WIDTH), .OUT_W(EXT_W)) u_ext_b (
        .is_signed (is_signed),
        .din       (multiplier),
        .dout      (b_ext)
    );

    assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_step = (state_q == S_RUN) && (cnt_q == CNT_W'(ITER - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One Booth step: add the selected multiple of A into the upper half,
    // then shift the {hi, lo} pair right by two with sign fill. The
    // multiplier bits drain out of lo as product bits fill in from hi.
    always_comb begin
        digit  = booth_decode({lo_q[1:0], prev_q});
        a_acc  = {{2{a_q[EXT_W-1]}}, a_q};
        a2_acc = {a_q[EXT_W-1], a_q, 1'b0};
        addend = '0;
        case (digit)
            BD_POS1: addend = a_acc;
            BD_POS2: addend = a2_acc;
            BD_NEG1: addend = -a_acc;
            BD_NEG2: addend = -a2_acc;
            default: addend = '0;
        endcase
        sum        = hi_q + addend;
        next_hi    = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
        next_lo    = {sum[1:0], lo_q[EXT_W-1:2]};
        final_prod = {next_hi[WIDTH-3:0], next_lo};
        if (signed_q)
            final_ovf = !((&final_prod[2*WIDTH-1:WIDTH-1]) || !(|final_prod[2*WIDTH-1:WIDTH-1]));
        else
            final_ovf = |final_prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            prev_q    <= 1'b0;
            signed_q  <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            a_q      <= a_ext;
            hi_q     <= '0;
            lo_q     <= b_ext;
            prev_q   <= 1'b0;
            signed_q <= is_signed;
            cnt_q    <= '0;
        end else if (state_q == S_RUN) begin
            hi_q   <= next_hi;
            lo_q   <= next_lo;
            prev_q <= lo_q[1];
            if (last_step) begin
                cnt_q     <= '0;
                product_q <= final_prod;
                ovf_q     <= final_ovf;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;
    assign ovf     = ovf_q;

endmodule

// File: doc/mult_booth_r4.md
MULT_BOOTH_R4 -- requirements
Module: mult_booth_r4

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be even and >= 4.
REQ-002 Derived constant EXT_W = WIDTH+2, the extended operand width; ITER = WIDTH/2+1, the radix-4 iteration count.
REQ-003 clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request a new multiply; sampled only in IDLE or DONE.
REQ-006 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-007 multiplicand  input  WIDTH  operand A; captured with start.
REQ-008 multiplier  input  WIDTH  operand B; captured with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle pulse marking product valid.
REQ-011 product  output  2*WIDTH  full-width result.
REQ-012 ovf  output  1  product not representable in WIDTH bits (signed or unsigned per is_signed).

Function
REQ-013 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 IDLE or DONE with start=1 SHALL capture the operands and mode and enter RUN on the next edge; busy SHALL be 1 from that edge.
REQ-015 On capture, both operands SHALL be extended to EXT_W bits: top two bits replicate bit WIDTH-1 when is_signed=1, zero when is_signed=0.
REQ-016 RUN SHALL retire one radix-4 Booth digit per cycle from the extended multiplier (triplet with implicit 0 below LSB), adding 0, +/-A or +/-2A to an accumulator, then arithmetic-shifting right by 2.
REQ-017 An internal iteration counter SHALL count 0..ITER-1; RUN SHALL last exactly ITER cycles, then enter DONE.
REQ-018 Latency: start sampled at edge N -> done=1 and valid product during cycle N+1+ITER (18 cycles after the start edge for WIDTH=32).
REQ-019 done SHALL be 1 for exactly the one cycle following the RUN->DONE transition; busy SHALL be 0 in that cycle.
REQ-020 product and ovf SHALL hold their value from done until the next accepted start, then SHALL hold their previous value until the next done.
REQ-021 start while in RUN SHALL be ignored with no effect on operands, counter or result.
REQ-022 start during the done cycle SHALL be accepted (back-to-back), giving the same latency as from IDLE.
REQ-023 DONE without start SHALL return to IDLE on the next edge.
REQ-024 Accumulator arithmetic SHALL be EXT_W+2 bits wide; product = low 2*WIDTH bits of the final result; no operand value, including most-negative x most-negative, SHALL give a wrong product.
REQ-025 ovf, signed mode: the upper WIDTH+1 product bits are not all equal.
REQ-026 ovf, unsigned mode: the upper WIDTH product bits are not all zero.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, product=0, ovf=0, counter=0, without waiting for clock.
REQ-028 Reset asserted during RUN SHALL abandon the operation; no done pulse SHALL follow deassertion.
REQ-029 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-030 State encodings (IDLE/RUN/DONE) and the Booth digit-select encoding SHALL live in a shared package, alongside the EXT_W and ITER derivation helpers.
REQ-031 Operand extension SHALL be a separate parametrised sub-module sign_zero_extend (IN_W, OUT_W, is_signed input), instantiated twice.
REQ-032 The multiplier SHALL contain no combinational path from start or operands to any output.

Verification
REQ-033 WIDTH=32, signed, -3 x 5 -> done after 18 cycles, product 0xFFFF_FFFF_FFFF_FFF1, ovf=0.
REQ-034 Unsigned 0xFFFF_FFFF x 0xFFFF_FFFF -> product 0xFFFF_FFFE_0000_0001, ovf=1; same operands signed -> product 1, ovf=0.
REQ-035 Signed 0x8000_0000 x 0x8000_0000 -> product 0x4000_0000_0000_0000, ovf=1.
REQ-036 start pulses in RUN cycles 3 and 10 with different operands -> ignored; one done with the first result only.
REQ-037 reset_n low at RUN cycle 7 -> outputs zero immediately, no done; next start 7 x 6 unsigned -> product 42 after 18 cycles.
REQ-038 start held high through done -> second operation accepted in the done cycle, second done exactly 18 cycles after the first.
